// File: rtl/alu_pkg.sv
// Shared opcode/state encodings and framing constants for the UART ALU command path.
package alu_pkg;

    typedef enum logic [7:0] {
        OP_ECHO = 8'hEC,
        OP_ADD  = 8'hAD,
        OP_MUL  = 8'h63
    } alu_op_e;

    typedef enum logic [2:0] {
        HDR,
        ECHO,
        OPND,
        RESULT,
        DRAIN
    } alu_state_e;

    localparam int HDR_BYTES  = 4;
    localparam int OPND_BYTES = 4;

endpackage

// File: rtl/alu_cmd_fsm.sv
// Packet parser/executor between uart_rx and uart_tx: echo, 32-bit add, 32-bit multiply.
// Define ALU_MUL_EN to decode opcode 0x63 and build the 32x32 low-product multiplier.
//
// Handshake: a byte moves on a rising edge where tvalid && tready. m_axis_tvalid/tdata come
// straight from a 1-byte register that only reloads when it is empty or being drained, so
// tdata never moves while tvalid && !tready.
module alu_cmd_fsm
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_12mhz_i,
    input  logic                  reset_unsafe_i,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  busy_o,
    output logic                  error_o,
    output alu_state_e            dbg_state
);

    alu_state_e  state_q, state_d;
    logic [1:0]  hdr_idx_q;
    logic [7:0]  opcode_q;
    logic [7:0]  len_lo_q;
    logic [15:0] rem_q;
    logic [1:0]  widx_q;
    logic [23:0] wbuf_q;
    logic        first_q;
    logic [31:0] acc_q;
    logic [1:0]  ridx_q;
    logic [7:0]  out_data_q;
    logic        out_valid_q;
    logic        error_q;

    logic        s_hs, m_hs, hdr_done, rem_last;
    logic        is_arith, arith_ok;
    logic [15:0] len_full, rem_init;
    logic [31:0] word, op_result, acc_next;

    assign s_hs     = s_axis_tvalid && s_axis_tready;
    assign m_hs     = out_valid_q && m_axis_tready;
    assign hdr_done = (state_q == HDR) && s_hs && (hdr_idx_q == 2'(HDR_BYTES - 1));
    assign rem_last = (rem_q == 16'd1);
    assign len_full = {s_axis_tdata, len_lo_q};
    // LEN below the header size is treated as a bare header with no payload.
    assign rem_init = (len_full < 16'(HDR_BYTES)) ? 16'd0 : len_full - 16'(HDR_BYTES);
    assign word     = {s_axis_tdata, wbuf_q};

`ifdef ALU_MUL_EN
    assign is_arith  = (opcode_q == OP_ADD) || (opcode_q == OP_MUL);
    assign op_result = (opcode_q == OP_MUL) ? acc_q * word : acc_q + word;
`else
    assign is_arith  = (opcode_q == OP_ADD);
    assign op_result = acc_q + word;
`endif

    assign arith_ok = is_arith && (len_full >= 16'd8) && (len_full[1:0] == 2'b00);
    assign acc_next = first_q ? word : op_result;

    always_ff @(posedge clk_12mhz_i) begin
        if (reset_unsafe_i) state_q <= HDR;
        else                state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HDR: begin
                if (hdr_done) begin
                    if (opcode_q == OP_ECHO)  state_d = (rem_init == 16'd0) ? HDR : ECHO;
                    else if (arith_ok)        state_d = OPND;
                    else                      state_d = (rem_init == 16'd0) ? HDR : DRAIN;
                end
            end
            ECHO:    if (rem_q == 16'd0 && (!out_valid_q || m_axis_tready)) state_d = HDR;
            OPND:    if (s_hs && rem_last) state_d = RESULT;
            RESULT:  if (m_hs && ridx_q == 2'd3) state_d = HDR;
            DRAIN:   if (s_hs && rem_last) state_d = HDR;
            default: state_d = HDR;
        endcase
    end

    always_comb begin
        s_axis_tready = 1'b0;
        case (state_q)
            HDR, OPND, DRAIN: s_axis_tready = 1'b1;
            // Stop taking bytes once the payload is exhausted so the next header is not eaten.
            ECHO:             s_axis_tready = (rem_q != 16'd0) && (!out_valid_q || m_axis_tready);
            default:          s_axis_tready = 1'b0;
        endcase
        busy_o        = (state_q != HDR);
        error_o       = error_q;
        m_axis_tdata  = out_data_q;
        m_axis_tvalid = out_valid_q;
        dbg_state     = state_q;
    end

    always_ff @(posedge clk_12mhz_i) begin
        if (reset_unsafe_i) begin
            hdr_idx_q   <= 2'd0;
            opcode_q    <= 8'd0;
            len_lo_q    <= 8'd0;
            rem_q       <= 16'd0;
            widx_q      <= 2'd0;
            wbuf_q      <= 24'd0;
            first_q     <= 1'b1;
            acc_q       <= 32'd0;
            ridx_q      <= 2'd0;
            out_data_q  <= 8'd0;
            out_valid_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            error_q <= hdr_done && (opcode_q != OP_ECHO) && !arith_ok;
            case (state_q)
                HDR: begin
                    if (s_hs) begin
                        hdr_idx_q <= hdr_idx_q + 2'd1;
                        if (hdr_idx_q == 2'd0) opcode_q <= s_axis_tdata;
                        if (hdr_idx_q == 2'd2) len_lo_q <= s_axis_tdata;
                    end
                    if (hdr_done) begin
                        rem_q   <= rem_init;
                        widx_q  <= 2'd0;
                        first_q <= 1'b1;
                        ridx_q  <= 2'd0;
                    end
                end
                ECHO: begin
                    if (s_hs) begin
                        out_data_q  <= s_axis_tdata;
                        out_valid_q <= 1'b1;
                        rem_q       <= rem_q - 16'd1;
                    end else if (m_axis_tready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                OPND: begin
                    if (s_hs) begin
                        rem_q  <= rem_q - 16'd1;
                        widx_q <= widx_q + 2'd1;
                        wbuf_q <= {s_axis_tdata, wbuf_q[23:8]};
                        if (widx_q == 2'(OPND_BYTES - 1)) begin
                            acc_q   <= acc_next;
                            first_q <= 1'b0;
                        end
                        // Byte 0 of the result is loaded on the same edge as the last operand.
                        if (rem_last) begin
                            out_data_q  <= acc_next[7:0];
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                RESULT: begin
                    if (m_hs) begin
                        ridx_q <= ridx_q + 2'd1;
                        case (ridx_q)
                            2'd0:    out_data_q <= acc_q[15:8];
                            2'd1:    out_data_q <= acc_q[23:16];
                            2'd2:    out_data_q <= acc_q[31:24];
                            default: out_valid_q <= 1'b0;
                        endcase
                    end
                end
                DRAIN: begin
                    if (s_hs) rem_q <= rem_q - 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_fsm.sv
// Directed bench for alu_cmd_fsm: packet-level reference model, per-cycle output compare.
module tb_alu_cmd_fsm;
    import alu_pkg::*;

    typedef logic [7:0] byte_q_t[$];

`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_unsafe_i;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       busy_o;
    logic       error_o;
    alu_state_e dbg_state;

    alu_cmd_fsm #(.DATA_WIDTH(8)) dut (
        .clk_12mhz_i   (clk),
        .reset_unsafe_i(reset_unsafe_i),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy_o        (busy_o),
        .error_o       (error_o),
        .dbg_state     (dbg_state)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    int         exp_err  = 0;
    int         err_seen = 0;
    bit         rand_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: whole packet in, expected response bytes / error pulses out.
    task automatic model_push(input byte_q_t p);
        logic [7:0]  op;
        int          len;
        logic [31:0] acc, w;
        op  = p[0];
        len = {p[3], p[2]};
        if (op == 8'hEC) begin
            for (int i = 4; i < len && i < p.size(); i++) exp_q.push_back(p[i]);
        end else if ((op == 8'hAD || (MUL_EN && op == 8'h63)) && len >= 8 && len % 4 == 0) begin
            acc = 32'd0;
            for (int k = 0; k < (len - 4) / 4; k++) begin
                w = {p[4+4*k+3], p[4+4*k+2], p[4+4*k+1], p[4+4*k]};
                if (k == 0)          acc = w;
                else if (op == 8'hAD) acc = acc + w;
                else                  acc = acc * w;
            end
            for (int b = 0; b < 4; b++) exp_q.push_back(acc[8*b +: 8]);
        end else begin
            exp_err++;
        end
    endtask

    task automatic pin_model(input string name, input int exp_len, input logic [31:0] exp_word);
        chk({name, "_len"}, exp_q.size(), exp_len);
        if (exp_q.size() == 4) chk({name, "_word"}, {exp_q[3], exp_q[2], exp_q[1], exp_q[0]}, exp_word);
    endtask

    // driver: called at posedge+1, returns at posedge+1 after the byte is taken
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        while (!s_axis_tready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!s_axis_tready) begin
            n_checks++;
            $display("FAIL send_timeout: tready=0 after 2000 cycles, required 1 (byte %h)", b);
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input byte_q_t p);
        foreach (p[i]) send_byte(p[i]);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 500; i++) begin
            if (exp_q.size() == 0 && !busy_o) break;
            @(posedge clk);
            #1;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk({name, "_pending"}, exp_q.size(), 0);
        chk({name, "_busy"}, busy_o, 1'b0);
        chk({name, "_errors"}, err_seen, exp_err);
    endtask

    task automatic run_pkt(input string name, input byte_q_t p);
        model_push(p);
        send_pkt(p);
        wait_idle(name);
    endtask

    // output sink
    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // scoreboard: every output handshake, stall stability, error pulses
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'd0;
    always @(negedge clk) begin
        if (reset_unsafe_i) begin
            prev_stall = 1'b0;
        end else begin
            if (error_o) err_seen++;
            if (prev_stall) begin
                chk("stall_valid", m_axis_tvalid, 1'b1);
                chk("stall_data", m_axis_tdata, prev_data);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_out: got byte %h, required no output", m_axis_tdata);
                end else begin
                    chk("out_byte", m_axis_tdata, exp_q.pop_front());
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
        end
    end

    task automatic check_reset_values(input string name);
        @(negedge clk);
        chk({name, "_state"}, dbg_state, HDR);
        chk({name, "_mvalid"}, m_axis_tvalid, 1'b0);
        chk({name, "_mdata"}, m_axis_tdata, 8'h00);
        chk({name, "_busy"}, busy_o, 1'b0);
        chk({name, "_error"}, error_o, 1'b0);
        chk({name, "_sready"}, s_axis_tready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        byte_q_t p;
        reset_unsafe_i = 1'b1;
        s_axis_tdata   = 8'h00;
        s_axis_tvalid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_unsafe_i = 1'b0;
        check_reset_values("reset");

        p = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
        model_push(p);
        pin_model("pin_add", 4, 32'h0000_0003);
        send_pkt(p);
        wait_idle("add");

        p = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
        model_push(p);
        pin_model("pin_wrap", 4, 32'h0000_0001);
        send_pkt(p);
        wait_idle("add_wrap");

        p = '{8'h63, 8'h00, 8'h0C, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        model_push(p);
`ifdef ALU_MUL_EN
        pin_model("pin_mul", 4, 32'hFFFF_FFFD);
`else
        pin_model("pin_mul_off", 0, 32'h0);
        chk("pin_mul_off_err", exp_err, 1);
`endif
        send_pkt(p);
        wait_idle("mul");

        rand_ready = 1'b1;
        p = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
        model_push(p);
        chk("pin_echo_len", exp_q.size(), 3);
        send_pkt(p);
        wait_idle("echo_bp");

        p = '{8'h5A, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22};
        run_pkt("unknown", p);
        p = '{8'hAD, 8'h00, 8'h07, 8'h00, 8'h01, 8'h02, 8'h03};
        run_pkt("bad_len", p);
        p = '{8'hAD, 8'h00, 8'h10, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00,
              8'h20, 8'h00, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00, 8'h00};
        model_push(p);
        pin_model("pin_add3", 4, 32'h0000_0060);
        send_pkt(p);
        wait_idle("add3");

        p = '{8'hEC, 8'h00, 8'h04, 8'h00};
        run_pkt("echo_empty", p);

        p = '{8'hEC, 8'h00, 8'd24, 8'h00};
        for (int i = 0; i < 20; i++) p.push_back(8'($urandom_range(0, 255)));
        run_pkt("echo_long", p);

        p = '{8'h63, 8'h00, 8'h10, 8'h00, 8'h07, 8'h00, 8'h01, 8'h00,
              8'h05, 8'h00, 8'h00, 8'h10, 8'h03, 8'h00, 8'h00, 8'h00};
        run_pkt("mul3", p);

        rand_ready = 1'b0;
        p = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        model_push(p);
        pin_model("pin_add1", 4, 32'h1234_5678);
        send_pkt(p);
        wait_idle("add_single");

        // reset in the middle of an ADD packet
        p = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00};
        send_pkt(p);
        reset_unsafe_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_unsafe_i = 1'b0;
        check_reset_values("midreset");
        p = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h99};
        model_push(p);
        chk("pin_post_reset", exp_q[0], 8'h99);
        send_pkt(p);
        wait_idle("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_cmd_fsm.md
# alu_cmd_fsm

Command processor between the UART receiver's AXI-Stream output and the UART transmitter's AXI-Stream input inside the UART ALU top. It parses byte packets arriving from `uart_rx`, executes echo, 32-bit add or 32-bit multiply, and streams the response bytes to `uart_tx`. It has one clock, no internal FIFO and one packet in flight at a time.

## Interface
- `DATA_WIDTH`, 8: stream byte width. Only 8 is supported.
- `clk_12mhz_i`  in  1  system clock.
- `reset_unsafe_i`  in  1  reset, synchronous, active-high.
- `s_axis_tdata`  in  8  received byte from `uart_rx`.
- `s_axis_tvalid`  in  1  received byte valid.
- `s_axis_tready`  out  1  block accepts a byte.
- `m_axis_tdata`  out  8  response byte to `uart_tx`.
- `m_axis_tvalid`  out  1  response byte valid.
- `m_axis_tready`  in  1  `uart_tx` accepts a byte.
- `busy_o`  out  1  high whenever state is not HDR.
- `error_o`  out  1  one-cycle pulse on a malformed or unknown packet.

## Operation
- Packet layout: byte0 is the opcode, byte1 is reserved (ignored), bytes 2–3 are LEN (little-endian, total packet bytes including the 4-byte header), followed by the payload of LEN−4 bytes.
- Opcodes:
  - 0xEC ECHO: payload bytes are forwarded unchanged.
  - 0xAD ADD: payload is N little-endian 32-bit operands. The response is the sum mod 2^32 as 4 bytes, little-endian.
  - 0x63 MUL: same framing as ADD. The response is the low 32 bits of the product.
- States:
  - HDR: collects 4 bytes with a 2-bit index.
    - ECHO opcode goes to ECHO.
    - ADD/MUL with LEN≥8 and LEN[1:0]==0 goes to OPND.
    - Any other case goes to DRAIN (LEN<4 is treated as 4, so DRAIN ends immediately).
  - ECHO: `s_axis_tready = !m_axis_tvalid || m_axis_tready`, using a 1-byte output register. Stays in ECHO until the remaining count is 0 and the output register is empty, then goes to HDR. LEN==4 returns to HDR immediately with no output.
  - OPND: assembles 4-byte words. The first word loads the accumulator; each later word does acc = acc op word. After the last payload byte goes to RESULT.
  - RESULT: `s_axis_tready` = 0. Emits acc[7:0], [15:8], [23:16], [31:24] in order, each held until its handshake. After byte 3 goes to HDR.
  - DRAIN: accepts and discards the remaining payload bytes. `error_o` pulses the cycle DRAIN is entered. Goes to HDR when the remaining count reaches 0.
- `s_axis_tready` is 1 in HDR, OPND and DRAIN.
- Remaining-byte counter is 16 bits and decrements per accepted payload byte. LEN=0xFFFF is legal.
- Reset values: state=HDR, `m_axis_tvalid`=0, `m_axis_tdata`=0, acc=0, `busy_o`=0, `error_o`=0, `s_axis_tready`=1 on the first cycle after reset deasserts.
- Reset mid-packet discards all partial state with no output and no error pulse. Bytes that follow are parsed as a new header.
- `m_axis_tdata` must not change while `m_axis_tvalid && !m_axis_tready`.

## Timing
- A byte transfers on a rising edge with tvalid && tready.
- Header: the state changes on the edge that accepts byte 3.
- ECHO: each byte appears on `m_axis_tvalid` 1 cycle after its input handshake. Sustained throughput is 1 byte/cycle when `m_axis_tready`=1.
- ADD/MUL: the accumulator updates on the edge accepting each word's 4th byte, with no extra compute cycle. Result byte0 is valid 1 cycle after the last payload handshake.
- After the final response handshake (or the end of DRAIN), HDR is active on the next cycle.
- Per-packet overhead beyond byte handshakes is at most 1 cycle.

## Configuration
- `ALU_MUL_EN` defined: opcode 0x63 is decoded and a 32×32 low-product multiplier is instantiated.
- `ALU_MUL_EN` undefined: no multiplier exists. 0x63 is an unknown opcode (DRAIN plus `error_o` pulse, no response).

## Structure
- Package `alu_pkg` holds:
  - opcode enum (OP_ECHO=8'hEC, OP_ADD=8'hAD, OP_MUL=8'h63);
  - state enum (HDR, ECHO, OPND, RESULT, DRAIN);
  - HDR_BYTES=4 and OPND_BYTES=4.
- Single module, no sub-module. The 1-byte output register is inline and shared by ECHO and RESULT.

## Test plan
- ADD: in AD 00 0C 00 01 00 00 00 02 00 00 00 -> out 03 00 00 00; `error_o` never asserted.
- ADD wrap: in AD 00 0C 00 FF FF FF FF 02 00 00 00 -> out 01 00 00 00.
- MUL (`ALU_MUL_EN` defined): in 63 00 0C 00 03 00 00 00 FF FF FF FF -> out FD FF FF FF. Without the macro: no output and one `error_o` pulse.
- ECHO with random `m_axis_tready` backpressure: in EC 00 07 00 41 42 43 -> out exactly 41 42 43, data stable while stalled.
- Unknown/malformed: in 5A 00 06 00 11 22 -> no output, one `error_o` pulse. Then in AD 00 07 00 … (LEN not a multiple of 4) -> drained, one pulse. A following valid ADD packet gives a correct result.
- Reset after 6 bytes of an ADD packet -> `m_axis_tvalid` stays 0. A new ECHO packet EC 00 05 00 99 -> out 99.
